// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MDU_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] X0              = 5'd0;
  localparam int         MDU_TIMEOUT_DEF = 64;
  localparam int         CNT_W_DEF       = 16;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, MDU hold with timeout, branch flush.
//   state      | meaning
//   S_RUN      | normal issue; load-use and branch rules apply
//   S_MDU_WAIT | multi-cycle MDU op occupies EX; front end held until done/timeout
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             MemRead_ex,
  input  logic             branch_taken_ex,
  input  logic             mdu_start_ex,
  input  logic             mdu_done,
  input  logic             cnt_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             flush_id,
  output logic             mdu_abort,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int            WW        = $clog2(MDU_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MDU_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          lu;
  logic          mh;
  logic          timeout_hit;

  assign lu = MemRead_ex && (rd_ex != X0) &&
              ((use_rs1_id && (rd_ex == rs1_id)) || (use_rs2_id && (rd_ex == rs2_id)));

  assign timeout_hit = (state == S_MDU_WAIT) && (wait_cnt == WAIT_LAST) && !mdu_done;

  assign mh = ((state == S_RUN) && mdu_start_ex && !mdu_done) ||
              ((state == S_MDU_WAIT) && !mdu_done && !timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:      if (mdu_start_ex && !mdu_done) state_nxt = S_MDU_WAIT;
      S_MDU_WAIT: if (mdu_done || timeout_hit)   state_nxt = S_RUN;
      default:    state_nxt = S_RUN;
    endcase
  end

  // Holding the count at zero throughout S_RUN gives a cleared value on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_RUN) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_timeout <= 1'b0;
    end else if (timeout_hit) begin
      mdu_timeout <= 1'b1;
    end
  end

  // Controls are gated by rst_n so the pipeline sees no stray holds during reset.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    flush_id   = 1'b0;
    mdu_abort  = 1'b0;
    if (rst_n) begin
      mdu_abort = timeout_hit;
      if (mh) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        stall_ex   = 1'b1;
        bubble_mem = 1'b1;
      end else if (branch_taken_ex) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (lu) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if),
    .clr   (cnt_clr),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_id),
    .clr   (cnt_clr),
    .q     (flush_cnt)
  );

endmodule
